// File: rtl/pipe_axi_rd_arbiter.sv
// pipe_axi_rd_arbiter: shares one AXI read port between IFU and LSU, LSU has fixed priority.
// One transaction is outstanding at a time, and there is one idle bubble between transactions.
module pipe_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  ifu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  input  logic                  lsu_rready_i,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_rready_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                  state;
  logic                    owner_lsu;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    idle, grant_lsu, grant_ifu, to_ifu, to_lsu;
  // Grants are gated by reset so no arready escapes while rst_i is held.
  assign idle          = state == IDLE && !rst_i;
  assign grant_lsu     = idle && lsu_arvalid_i;
  assign grant_ifu     = idle && !lsu_arvalid_i && ifu_arvalid_i;
  assign to_ifu        = state == DATA && !owner_lsu;
  assign to_lsu        = state == DATA && owner_lsu;
  assign ifu_arready_o = grant_ifu;
  assign lsu_arready_o = grant_lsu;
  assign mem_arvalid_o = state == ADDR;
  assign mem_araddr_o  = addr_q;
  assign mem_rready_o  = to_lsu ? lsu_rready_i : to_ifu ? ifu_rready_i : 1'b0;
  assign ifu_rvalid_o  = to_ifu && mem_rvalid_i;
  assign lsu_rvalid_o  = to_lsu && mem_rvalid_i;
  assign ifu_rdata_o   = to_ifu ? mem_rdata_i : '0;
  assign lsu_rdata_o   = to_lsu ? mem_rdata_i : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: if (grant_lsu || grant_ifu) begin
          state     <= ADDR;
          owner_lsu <= grant_lsu;
          addr_q    <= grant_lsu ? lsu_araddr_i : ifu_araddr_i;
        end
        ADDR: if (mem_arready_i) state <= DATA;
        DATA: if (mem_rvalid_i && mem_rready_o) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pipe_axi_rd_arbiter.md
PIPE_AXI_RD_ARBITER -- requirements
Module: pipe_axi_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, read address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, read data width in bits.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 ifu_araddr_i  input  ADDR_WIDTH  IFU read address.
REQ-006 ifu_arvalid_i  input  1  IFU read request.
REQ-007 ifu_arready_o  output  1  IFU address accepted.
REQ-008 ifu_rvalid_o  output  1  IFU read data valid.
REQ-009 ifu_rdata_o  output  DATA_WIDTH  IFU read data.
REQ-010 ifu_rready_i  input  1  IFU can take data.
REQ-011 lsu_araddr_i  input  ADDR_WIDTH  LSU load address.
REQ-012 lsu_arvalid_i  input  1  LSU load request.
REQ-013 lsu_arready_o  output  1  LSU address accepted.
REQ-014 lsu_rvalid_o  output  1  LSU read data valid.
REQ-015 lsu_rdata_o  output  DATA_WIDTH  LSU read data.
REQ-016 lsu_rready_i  input  1  LSU can take data.
REQ-017 mem_araddr_o  output  ADDR_WIDTH  shared-port read address.
REQ-018 mem_arvalid_o  output  1  shared-port request.
REQ-019 mem_arready_i  input  1  shared port accepted address.
REQ-020 mem_rvalid_i  input  1  shared-port data valid.
REQ-021 mem_rdata_i  input  DATA_WIDTH  shared-port data.
REQ-022 mem_rready_o  output  1  shared-port data accepted.

Function
REQ-023 FSM states: IDLE, ADDR, DATA. Owner register: IFU or LSU. Address register: ADDR_WIDTH bits. One transaction outstanding at most.
REQ-024 IDLE grant: owner is LSU if lsu_arvalid_i=1 (fixed priority), else IFU if ifu_arvalid_i=1, else no grant.
REQ-025 Grant cycle, combinational: the granted requester's arready_o=1, the other requester's arready_o=0. The arbiter latches the owner and that requester's araddr and moves to ADDR.
REQ-026 In IDLE, both arready_o SHALL be 0 when no request is present. In ADDR and DATA, both arready_o SHALL be 0.
REQ-027 ADDR: mem_arvalid_o=1. mem_araddr_o comes from the latched register and stays stable while in ADDR. Requester address changes after the grant are ignored. On mem_arready_i=1 the FSM moves to DATA.
REQ-028 mem_arvalid_o SHALL be 0 outside ADDR.
REQ-029 DATA: owner's rvalid_o=mem_rvalid_i and owner's rdata_o=mem_rdata_i. mem_rready_o=owner's rready_i. The non-owner's rvalid_o=0.
REQ-030 mem_rready_o SHALL be 0 outside DATA.
REQ-031 On mem_rvalid_i & mem_rready_o the FSM returns to IDLE. A new grant is allowed no earlier than the next cycle, so there is one idle bubble per transaction.
REQ-032 A beat held in DATA while the owner's rready_i=0 SHALL stall with no data loss.
REQ-033 An owner that drops arvalid after its grant does not abort the transaction. The response is still delivered and must be handshaked.
REQ-034 The non-owner's rdata_o SHALL be 0.
REQ-035 Minimum latency with a zero-wait memory: grant cycle 0, mem_arvalid_o cycle 1, data forwarded in the cycle mem_rvalid_i arrives.

Reset
REQ-036 While rst_i=1, asynchronously: state=IDLE, owner=IFU, address register=0. All valid and ready outputs are 0.
REQ-037 If rst_i is asserted mid-transaction, the transaction is dropped. No response is forwarded after reset release.

Verification
REQ-038 IFU only, araddr=0x80000000, mem_arready_i=1, mem_rdata_i=0x00000013 one cycle later, ifu_rready_i=1 -> ifu_arready_o pulses once; mem_araddr_o=0x80000000; ifu_rvalid_o=1 with data 0x00000013; lsu_rvalid_o=0 throughout.
REQ-039 IFU and LSU both request in the same IDLE cycle (LSU 0x80001000) -> LSU granted first; mem_araddr_o=0x80001000; IFU granted in the cycle after the LSU response handshake.
REQ-040 IFU changes araddr 0x80000004->0x80000100 while in ADDR with mem_arready_i held 0 for 3 cycles -> mem_araddr_o stays 0x80000004.
REQ-041 DATA with mem_rvalid_i=1 and lsu_rready_i=0 for 2 cycles -> mem_rready_o=0 for both cycles; the FSM stays in DATA; the data is delivered on the first lsu_rready_i=1.
REQ-042 rst_i asserted during DATA -> all valid and ready outputs are 0 immediately; after release the FSM is in IDLE and grants new requests normally.
